// File: rtl/bram_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : bram_arbiter                                                 |
// | Description : Round-robin arbiter sharing one BRAM port between two        |
// |               requesters (P0, P1). Grants are combinational Req/Gnt        |
// |               handshakes. The winning access is registered onto the O_*    |
// |               port. Read data is routed back to the issuing requester      |
// |               through a tag pipeline that keeps issue order.               |
// | Options     : define BRAM_ARB_BURST_LOCK_EN to let the current owner keep  |
// |               the grant under contention for up to MAX_BURST consecutive   |
// |               accepts. Without it the arbiter is strict per-accept         |
// |               round-robin and no burst counter exists.                     |
// | Ports       : Clk/Rst            clock, synchronous active-high reset      |
// |               Px_Req/Addr/Din/WEN requester x access (WEN==0 means read)   |
// |               Px_Gnt             combinational grant                       |
// |               Px_Dout/Px_Dvalid  registered read return, one-cycle pulse   |
// |               O_Addr/EN/Din/WEN  registered BRAM port drive               |
// |               O_Dout             BRAM read data                            |
// |               O_Clk/O_Rst        Clk/Rst passed through to the BRAM        |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module bram_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int WEN_WIDTH  = DATA_WIDTH / 8 + (((DATA_WIDTH % 8) != 0) ? 1 : 0),
  parameter int RD_LATENCY = 1,
  parameter int MAX_BURST  = 4
) (
  input  logic                  Clk,
  input  logic                  Rst,
  input  logic                  P0_Req,
  input  logic [ADDR_WIDTH-1:0] P0_Addr,
  input  logic [DATA_WIDTH-1:0] P0_Din,
  input  logic [WEN_WIDTH-1:0]  P0_WEN,
  output logic                  P0_Gnt,
  output logic [DATA_WIDTH-1:0] P0_Dout,
  output logic                  P0_Dvalid,
  input  logic                  P1_Req,
  input  logic [ADDR_WIDTH-1:0] P1_Addr,
  input  logic [DATA_WIDTH-1:0] P1_Din,
  input  logic [WEN_WIDTH-1:0]  P1_WEN,
  output logic                  P1_Gnt,
  output logic [DATA_WIDTH-1:0] P1_Dout,
  output logic                  P1_Dvalid,
  output logic [ADDR_WIDTH-1:0] O_Addr,
  output logic                  O_EN,
  output logic [DATA_WIDTH-1:0] O_Din,
  output logic [WEN_WIDTH-1:0]  O_WEN,
  input  logic [DATA_WIDTH-1:0] O_Dout,
  output logic                  O_Clk,
  output logic                  O_Rst
);

  // Elaboration-time sanity check of the configuration.
  generate
    if (RD_LATENCY < 1 || RD_LATENCY > 3 || MAX_BURST < 1 || MAX_BURST > 255) begin : g_param_check
      $error("bram_arbiter: RD_LATENCY must be 1..3 and MAX_BURST 1..255");
    end
  endgenerate

  // last_grant_q: 0 = P0 was granted last, 1 = P1. Resets to P1 so P0 wins first contention.
  logic                  last_grant_q;
  logic                  w_keep_owner;
  logic                  w_gnt0;
  logic                  w_gnt1;
  logic                  w_accept;
  logic [ADDR_WIDTH-1:0] w_addr;
  logic [DATA_WIDTH-1:0] w_din;
  logic [WEN_WIDTH-1:0]  w_wen;
  logic                  w_rd_accept;

  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  en_q;
  logic [DATA_WIDTH-1:0] din_q;
  logic [WEN_WIDTH-1:0]  wen_q;

  // Read tag pipeline: stage k holds the tag of the read whose O_EN cycle was k cycles ago,
  // so the last stage lines up with O_Dout being valid.
  logic [RD_LATENCY:0]   tag_v_q;
  logic [RD_LATENCY:0]   tag_id_q;

  logic                  dvalid0_q;
  logic                  dvalid1_q;
  logic [DATA_WIDTH-1:0] dout0_q;
  logic [DATA_WIDTH-1:0] dout1_q;

`ifdef BRAM_ARB_BURST_LOCK_EN
  localparam logic [7:0] BURST_MAX = 8'(MAX_BURST);

  // Consecutive accepts by the port in last_grant_q; zero after an idle cycle.
  logic [7:0] burst_cnt_q;
  logic [7:0] burst_cnt_d;

  // Owner holds the grant only while a streak is running and below the limit.
  assign w_keep_owner = (burst_cnt_q != 8'd0) && (burst_cnt_q < BURST_MAX);

  always_comb begin
    burst_cnt_d = 8'd0;
    if (w_accept) begin
      if (w_gnt1 != last_grant_q) begin
        burst_cnt_d = 8'd1;
      end else if (burst_cnt_q != BURST_MAX) begin
        burst_cnt_d = burst_cnt_q + 8'd1;
      end else begin
        burst_cnt_d = burst_cnt_q;   // saturate: a lone requester is never limited
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      burst_cnt_q <= 8'd0;
    end else begin
      burst_cnt_q <= burst_cnt_d;
    end
  end
`else
  assign w_keep_owner = 1'b0;
`endif

  // Grant decision. Grants are suppressed for the whole reset cycle.
  always_comb begin
    w_gnt0 = 1'b0;
    w_gnt1 = 1'b0;
    if (!Rst) begin
      if (P0_Req && P1_Req) begin
        if (w_keep_owner) begin
          w_gnt1 = last_grant_q;
        end else begin
          w_gnt1 = ~last_grant_q;
        end
        w_gnt0 = ~w_gnt1;
      end else begin
        w_gnt0 = P0_Req;
        w_gnt1 = P1_Req;
      end
    end
  end

  assign w_accept    = w_gnt0 | w_gnt1;
  assign w_addr      = w_gnt1 ? P1_Addr : P0_Addr;
  assign w_din       = w_gnt1 ? P1_Din  : P0_Din;
  assign w_wen       = w_gnt1 ? P1_WEN  : P0_WEN;
  assign w_rd_accept = w_accept && (w_wen == '0);

  always_ff @(posedge Clk) begin
    if (Rst) begin
      last_grant_q <= 1'b1;
      addr_q       <= '0;
      en_q         <= 1'b0;
      din_q        <= '0;
      wen_q        <= '0;
      tag_v_q      <= '0;
      tag_id_q     <= '0;
      dvalid0_q    <= 1'b0;
      dvalid1_q    <= 1'b0;
      dout0_q      <= '0;
      dout1_q      <= '0;
    end else begin
      if (w_accept) begin
        last_grant_q <= w_gnt1;
        en_q         <= 1'b1;
        addr_q       <= w_addr;
        din_q        <= w_din;
        wen_q        <= w_wen;
      end else begin
        // Address and data hold so the BRAM inputs stay quiet between accesses.
        en_q  <= 1'b0;
        wen_q <= '0;
      end

      tag_v_q  <= {tag_v_q[RD_LATENCY-1:0], w_rd_accept};
      tag_id_q <= {tag_id_q[RD_LATENCY-1:0], w_gnt1};

      dvalid0_q <= tag_v_q[RD_LATENCY] & ~tag_id_q[RD_LATENCY];
      dvalid1_q <= tag_v_q[RD_LATENCY] &  tag_id_q[RD_LATENCY];
      if (tag_v_q[RD_LATENCY] && !tag_id_q[RD_LATENCY]) begin
        dout0_q <= O_Dout;
      end
      if (tag_v_q[RD_LATENCY] && tag_id_q[RD_LATENCY]) begin
        dout1_q <= O_Dout;
      end
    end
  end

  assign P0_Gnt    = w_gnt0;
  assign P1_Gnt    = w_gnt1;
  assign P0_Dout   = dout0_q;
  assign P1_Dout   = dout1_q;
  assign P0_Dvalid = dvalid0_q;
  assign P1_Dvalid = dvalid1_q;
  assign O_Addr    = addr_q;
  assign O_EN      = en_q;
  assign O_Din     = din_q;
  assign O_WEN     = wen_q;
  assign O_Clk     = Clk;
  assign O_Rst     = Rst;

endmodule
`default_nettype wire
